// File: rtl/subcpu_ctrl.sv
// Sub-CPU glue: E/Q clock generation, address decode, VBLANK interrupt and watchdog reset.
// E/Q/nIRQ/nRES are registered on CLK_6M; nCS/nBUFEN follow A/nWE/E combinationally.
module subcpu_ctrl #(
  parameter int                   NUM_CS     = 8,
  parameter logic [16*NUM_CS-1:0] CS_BASE    = '0,
  parameter logic [16*NUM_CS-1:0] CS_MASK    = '0,
  parameter logic [2*NUM_CS-1:0]  CS_MODE    = '0,
  parameter logic [NUM_CS-1:0]    CS_EGATE   = '0,
  parameter logic [NUM_CS-1:0]    BUF_MASK   = '0,
  parameter int                   WDT_WIDTH  = 4,
  parameter int                   WDT_LIMIT  = 10,
  parameter logic [15:0]          WDT_ADDR   = 16'h8000,
  parameter logic [15:0]          WDT_MASK   = 16'hFC00,
  parameter logic [15:0]          ACK_ADDR   = 16'h8400,
  parameter logic [15:0]          ACK_MASK   = 16'hFC00,
  parameter int                   RES_CYCLES = 64
) (
  input  logic              CLK_6M,
  input  logic              rst,
  input  logic              nVBLK,
  input  logic              nWE,
  input  logic [15:0]       A,
  output logic              E,
  output logic              Q,
  output logic              nRES,
  output logic              nIRQ,
  output logic [NUM_CS-1:0] nCS,
  output logic              nBUFEN
);

  localparam int RW = $clog2(RES_CYCLES + 1);
  localparam logic [WDT_WIDTH-1:0] WDT_TRIP = WDT_WIDTH'(WDT_LIMIT - 1);
  localparam logic [RW-1:0] RES_LOAD = RW'(RES_CYCLES);

  if ((WDT_LIMIT > (2 ** WDT_WIDTH) - 1) || (WDT_LIMIT < 1)) begin : gWdtLimitErr
    $error("WDT_LIMIT does not fit the watchdog counter");
  end

  logic [1:0]           ph;
  logic [1:0]           phNext;
  logic [2:0]           syncQ;
  logic [WDT_WIDTH-1:0] wdtCnt;
  logic [RW-1:0]        resCnt;
  logic                 wrStb;
  logic                 vblStb;
  logic                 ackWr;
  logic                 kickWr;

  assign phNext = ph + 2'd1;

  // E/Q are computed from the next phase so they line up with ph itself.
  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      ph <= 2'd0;
      E  <= 1'b0;
      Q  <= 1'b0;
    end else begin
      ph <= phNext;
      E  <= phNext[1];
      Q  <= phNext[1] ^ phNext[0];
    end
  end

  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      syncQ <= 3'b111;
    end else begin
      syncQ <= {syncQ[1:0], nVBLK};
    end
  end

  assign vblStb = syncQ[2] & ~syncQ[1];
  assign wrStb  = (ph == 2'd3) & ~nWE;
  assign ackWr  = wrStb & (((A ^ ACK_ADDR) & ACK_MASK) == 16'h0);
  assign kickWr = wrStb & (((A ^ WDT_ADDR) & WDT_MASK) == 16'h0);

  always_ff @(posedge CLK_6M or posedge rst) begin
    if (rst) begin
      nIRQ   <= 1'b1;
      wdtCnt <= '0;
      nRES   <= 1'b0;
      resCnt <= RES_LOAD;
    end else if (!nRES) begin
      // Pulse in progress: bus and VBLANK events are ignored.
      nIRQ   <= 1'b1;
      wdtCnt <= '0;
      if (resCnt != '0) begin
        resCnt <= resCnt - 1'b1;
      end
      nRES <= (resCnt <= RW'(1));
    end else begin
      if (vblStb) begin
        nIRQ <= 1'b0;
      end else if (ackWr) begin
        nIRQ <= 1'b1;
      end
      if (kickWr) begin
        wdtCnt <= '0;
      end else if (vblStb) begin
        if (wdtCnt == WDT_TRIP) begin
          wdtCnt <= '0;
          resCnt <= RES_LOAD;
          nRES   <= 1'b0;
        end else begin
          wdtCnt <= wdtCnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CS; i++) begin : gCs
    logic addrHit;
    logic modeOk;
    logic gateOk;

    assign addrHit = ((A ^ CS_BASE[16*i +: 16]) & CS_MASK[16*i +: 16]) == 16'h0;

    always_comb begin
      modeOk = 1'b0;
      case (CS_MODE[2*i +: 2])
        2'b00:   modeOk = 1'b1;
        2'b01:   modeOk = nWE;
        2'b10:   modeOk = ~nWE;
        default: modeOk = 1'b0;
      endcase
    end

    assign gateOk = ~CS_EGATE[i] | E;
    assign nCS[i] = ~(addrHit & modeOk & gateOk);
  end

  assign nBUFEN = ~|(~nCS & BUF_MASK);

endmodule

// File: tb/tb_subcpu_ctrl.sv
// Directed bench for subcpu_ctrl: clocking, IRQ, watchdog, decode and async reset.
module tb_subcpu_ctrl;

  logic        CLK_6M;
  logic        rst;
  logic        nVBLK;
  logic        nWE;
  logic [15:0] A;
  logic        E;
  logic        Q;
  logic        nRES;
  logic        nIRQ;
  logic [1:0]  nCS;
  logic        nBUFEN;

  int nCmp = 0;
  int nErr = 0;
  int lowCnt = 0;
  logic monRes = 1'b0;
  logic [1:0] tbPh;
  logic [3:0] ePat = 4'b1100;
  logic [3:0] qPat = 4'b0110;

  subcpu_ctrl #(
    .NUM_CS   (2),
    .CS_BASE  (32'h8000_2000),
    .CS_MASK  (32'hF000_E000),
    .CS_MODE  (4'b0010),
    .CS_EGATE (2'b01),
    .BUF_MASK (2'b01)
  ) dut (
    .CLK_6M (CLK_6M),
    .rst    (rst),
    .nVBLK  (nVBLK),
    .nWE    (nWE),
    .A      (A),
    .E      (E),
    .Q      (Q),
    .nRES   (nRES),
    .nIRQ   (nIRQ),
    .nCS    (nCS),
    .nBUFEN (nBUFEN)
  );

  initial CLK_6M = 1'b0;
  always #5 CLK_6M = ~CLK_6M;

  // Phase reference for stimulus alignment.
  always @(posedge CLK_6M or posedge rst) begin
    if (rst) tbPh <= 2'd0;
    else     tbPh <= tbPh + 2'd1;
  end

  always @(negedge CLK_6M) begin
    if (monRes && !nRES) lowCnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic waitPh(input logic [1:0] p);
    for (int i = 0; i < 4 && tbPh != p; i++) tick();
  endtask

  task automatic busWrite(input logic [15:0] addr);
    waitPh(2'd3);
    A   = addr;
    nWE = 1'b0;
    tick();
    nWE = 1'b1;
  endtask

  task automatic vblank();
    nVBLK = 1'b0;
    repeat (3) tick();
    nVBLK = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; nVBLK = 1'b1; nWE = 1'b1; A = 16'h0000;
    repeat (3) @(posedge CLK_6M);
    #1;
    check("rst_E", E, 0);
    check("rst_Q", Q, 0);
    check("rst_nIRQ", nIRQ, 1);
    check("rst_nRES", nRES, 0);
    check("rst_wdt", 32'(dut.wdtCnt), 0);

    // Free-running E/Q and the power-on reset pulse.
    @(negedge CLK_6M);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      check("clk_E", E, ePat[i % 4]);
      check("clk_Q", Q, qPat[i % 4]);
    end
    repeat (48) tick();
    check("por_nres_63", nRES, 0);
    tick();
    check("por_nres_64", nRES, 1);

    // Interrupt set / acknowledge.
    repeat (3) tick();
    nVBLK = 1'b0;
    tick(); tick();
    check("irq_pre", nIRQ, 1);
    tick();
    check("irq_set", nIRQ, 0);
    repeat (3) tick();
    nVBLK = 1'b1;
    repeat (3) tick();
    busWrite(16'h8400);
    check("irq_ack", nIRQ, 1);

    // Ack write in the same cycle as vbl_stb: set must win.
    waitPh(2'd1);
    nVBLK = 1'b0;
    tick(); tick();
    A = 16'h8400; nWE = 1'b0;
    tick();
    nWE = 1'b1;
    check("irq_set_prio", nIRQ, 0);
    nVBLK = 1'b1;
    repeat (3) tick();
    check("irq_hold", nIRQ, 0);
    busWrite(16'h8400);
    check("irq_ack2", nIRQ, 1);
    check("wdt_cnt2", 32'(dut.wdtCnt), 2);
    busWrite(16'h8000);
    check("wdt_kick", 32'(dut.wdtCnt), 0);

    // Watchdog trip after ten unkicked VBLANKs.
    for (int v = 0; v < 9; v++) vblank();
    check("wdt_cnt9", 32'(dut.wdtCnt), 9);
    check("wdt_nres9", nRES, 1);
    nVBLK = 1'b0;
    tick(); tick();
    check("wdt_pre_trip", nRES, 1);
    tick();
    check("wdt_trip", nRES, 0);
    check("wdt_trip_cnt", 32'(dut.wdtCnt), 0);
    tick();
    check("wdt_irq_forced", nIRQ, 1);
    for (int i = 0; i < 62; i++) begin
      nVBLK = ((i / 4) % 2 == 1) ? 1'b0 : 1'b1;
      tick();
    end
    check("wdt_pulse_63", nRES, 0);
    check("wdt_hold0", 32'(dut.wdtCnt), 0);
    nVBLK = 1'b1;
    tick();
    check("wdt_pulse_64", nRES, 1);
    repeat (3) tick();
    check("wdt_vbl_ignored", 32'(dut.wdtCnt), 0);
    check("wdt_irq_after", nIRQ, 1);

    // Kick every 9th VBLANK over 100: no reset.
    lowCnt = 0;
    monRes = 1'b1;
    for (int v = 1; v <= 100; v++) begin
      vblank();
      if (v % 9 == 0) busWrite(16'h8000);
    end
    monRes = 1'b0;
    check("kick_nres_low", lowCnt, 0);
    check("kick_cnt_end", 32'(dut.wdtCnt), 1);

    // Kick write coinciding with vbl_stb: clear must win.
    waitPh(2'd1);
    nVBLK = 1'b0;
    tick(); tick();
    A = 16'h8000; nWE = 1'b0;
    tick();
    nWE = 1'b1;
    check("wdt_kick_prio", 32'(dut.wdtCnt), 0);
    nVBLK = 1'b1;
    repeat (3) tick();

    // Chip-select decode.
    waitPh(2'd2);
    A = 16'h2000; nWE = 1'b0; #1;
    check("cs_wr_2000", nCS, 2'b10);
    check("buf_wr_2000", nBUFEN, 0);
    A = 16'h3FFF; #1;
    check("cs_wr_3fff", nCS, 2'b10);
    A = 16'h4000; #1;
    check("cs_wr_4000", nCS, 2'b11);
    check("buf_wr_4000", nBUFEN, 1);
    waitPh(2'd3);
    A = 16'h1FFF; nWE = 1'b0; #1;
    check("cs_wr_1fff", nCS, 2'b11);
    A = 16'h2000; nWE = 1'b1; #1;
    check("cs_rd_2000", nCS, 2'b11);
    waitPh(2'd0);
    A = 16'h2000; nWE = 1'b0; #1;
    check("cs_egate_low", nCS, 2'b11);
    nWE = 1'b1;
    A = 16'h8123; #1;
    check("cs_any_8123", nCS, 2'b01);
    check("buf_any_8123", nBUFEN, 1);
    A = 16'h0000;
    tick();

    // Async reset in the middle of a watchdog pulse.
    for (int v = 0; v < 10; v++) vblank();
    check("rp_pulse_active", nRES, 0);
    repeat (5) tick();
    waitPh(2'd2);
    check("rp_E_before", E, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rp_E", E, 0);
    check("rp_Q", Q, 0);
    check("rp_nRES", nRES, 0);
    check("rp_nIRQ", nIRQ, 1);
    check("rp_resCnt", 32'(dut.resCnt), 64);
    @(posedge CLK_6M);
    #1;
    check("rp_E_held", E, 0);
    @(negedge CLK_6M);
    rst = 1'b0;
    #1;
    check("rp_Q_rel", Q, 0);
    tick();
    check("rp_E_1", E, 0);
    check("rp_Q_1", Q, 1);
    repeat (62) tick();
    check("rp_nres_63", nRES, 0);
    tick();
    check("rp_nres_64", nRES, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
